// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational from the registered table. One resolved
// control-transfer instruction may update the table per cycle. Saturating
// statistics count resolved updates and mispredictions.
module branch_predictor #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_jump,
    input  logic              upd_mispred,
    input  logic              clr,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] mp_cnt
);

    localparam int IDXW  = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - IDXW - 2;

    // Table state
    logic [DEPTH-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_reg    [DEPTH];
    logic [ADDR_W-1:0] target_reg [DEPTH];
    logic [1:0]        ctr_reg    [DEPTH];

    logic [STAT_W-1:0] br_cnt_reg;
    logic [STAT_W-1:0] mp_cnt_reg;

    // Address decomposition; pc[1:0] never participates in index or tag
    logic [IDXW-1:0]  lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDXW-1:0]  upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             unused_upd_pc_bits;

    assign lk_idx  = lk_pc[IDXW+1:2];
    assign lk_tag  = lk_pc[ADDR_W-1:IDXW+2];
    assign upd_idx = upd_pc[IDXW+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDXW+2];
    assign unused_upd_pc_bits = ^upd_pc[1:0];

    // Lookup: forced to a miss while reset is held so the fall-through is seen
    logic lk_hit;

    assign lk_hit      = !reset && valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_reg[lk_idx][1];
    assign pred_target = lk_hit ? target_reg[lk_idx] : lk_pc + ADDR_W'(4);

    // Update-side hit detection and next direction counter for a hitting entry
    logic       upd_hit;
    logic [1:0] ctr_cur;
    logic [1:0] ctr_next;

    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
    assign ctr_cur = ctr_reg[upd_idx];

    // Saturating counter step; jumps pin the counter to strongly taken
    always_comb begin
        ctr_next = ctr_cur;
        if (upd_jump) begin
            ctr_next = 2'b11;
        end else if (upd_taken) begin
            ctr_next = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
        end else begin
            ctr_next = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
        end
    end

    // Table maintenance: reset, invalidate-all (wins over update), hit update, allocation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                ctr_reg[i]    <= 2'b01;
            end
        end else if (clr) begin
            valid_reg <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_reg[upd_idx] <= ctr_next;
                if (upd_jump || upd_taken) begin
                    target_reg[upd_idx] <= upd_target;
                end
            end else if (upd_jump || upd_taken) begin
                valid_reg[upd_idx]  <= 1'b1;
                tag_reg[upd_idx]    <= upd_tag;
                target_reg[upd_idx] <= upd_target;
                ctr_reg[upd_idx]    <= upd_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // Saturating statistics; an update discarded by clr is not counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_reg <= '0;
            mp_cnt_reg <= '0;
        end else if (upd_valid && !clr) begin
            if (!(&br_cnt_reg)) begin
                br_cnt_reg <= br_cnt_reg + STAT_W'(1);
            end
            if (upd_mispred && !(&mp_cnt_reg)) begin
                mp_cnt_reg <= mp_cnt_reg + STAT_W'(1);
            end
        end
    end

    assign br_cnt = br_cnt_reg;
    assign mp_cnt = mp_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// reset/clear/saturation sequences and randomized traffic against a table model.
module tb_branch_predictor;

    localparam int DEPTH = 16;
    localparam int IDXW  = 4;

    logic        clk;
    logic        reset;
    logic [31:0] lk_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_jump;
    logic        upd_mispred;
    logic        clr;

    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] br_cnt;
    logic [31:0] mp_cnt;
    logic        pred_taken4;
    logic [31:0] pred_target4;
    logic [3:0]  br_cnt4;
    logic [3:0]  mp_cnt4;

    branch_predictor #(.DEPTH(DEPTH), .ADDR_W(32), .STAT_W(32)) u_dut (
        .clk(clk), .reset(reset), .lk_pc(lk_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_jump(upd_jump), .upd_mispred(upd_mispred),
        .clr(clr), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
    );

    branch_predictor #(.DEPTH(DEPTH), .ADDR_W(32), .STAT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .lk_pc(lk_pc),
        .pred_taken(pred_taken4), .pred_target(pred_target4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_jump(upd_jump), .upd_mispred(upd_mispred),
        .clr(clr), .br_cnt(br_cnt4), .mp_cnt(mp_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural table: entry = valid, tag, target, counter 0..3
    bit          m_valid  [DEPTH];
    longint      m_tag    [DEPTH];
    logic [31:0] m_target [DEPTH];
    int          m_ctr    [DEPTH];
    longint      m_br;
    longint      m_mp;

    typedef struct {
        logic [31:0] lk;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        uj;
        logic        ump;
        logic        c;
        logic        et;
        logic [31:0] etgt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int     idx;
        longint tg;
        bit     hit;
        idx = int'((pc >> 2) % DEPTH);
        tg  = longint'(pc >> (IDXW + 2));
        hit = m_valid[idx] && (m_tag[idx] == tg);
        t   = hit && (m_ctr[idx] >= 2);
        tgt = hit ? m_target[idx] : pc + 32'd4;
    endtask

    task automatic model_update(input vec_t v);
        int     idx;
        longint tg;
        if (v.c) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            return;
        end
        if (!v.uv) return;
        m_br++;
        if (v.ump) m_mp++;
        idx = int'((v.upc >> 2) % DEPTH);
        tg  = longint'(v.upc >> (IDXW + 2));
        if (m_valid[idx] && m_tag[idx] == tg) begin
            if (v.uj) begin
                m_ctr[idx] = 3;
                m_target[idx] = v.utgt;
            end else if (v.ut) begin
                m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                m_target[idx] = v.utgt;
            end else begin
                m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            end
        end else if (v.ut || v.uj) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = tg;
            m_target[idx] = v.utgt;
            m_ctr[idx]    = v.uj ? 3 : 2;
        end
    endtask

    // One cycle: drive inputs just after an edge, check before the next edge,
    // then advance the model across the edge.
    task automatic apply(input vec_t v, input bit use_exp, input string name);
        logic        mt;
        logic [31:0] mtgt;
        longint      e4b;
        longint      e4m;
        lk_pc = v.lk; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
        upd_target = v.utgt; upd_jump = v.uj; upd_mispred = v.ump; clr = v.c;
        @(negedge clk);
        model_lookup(v.lk, mt, mtgt);
        e4b = (m_br > 15) ? 15 : m_br;
        e4m = (m_mp > 15) ? 15 : m_mp;
        check({name, "_taken"}, 64'(pred_taken), 64'(mt));
        check({name, "_target"}, 64'(pred_target), 64'(mtgt));
        check({name, "_taken4"}, 64'(pred_taken4), 64'(mt));
        check({name, "_br"}, 64'(br_cnt), 64'(m_br));
        check({name, "_mp"}, 64'(mp_cnt), 64'(m_mp));
        check({name, "_br4"}, 64'(br_cnt4), 64'(e4b));
        check({name, "_mp4"}, 64'(mp_cnt4), 64'(e4m));
        if (use_exp) begin
            check({name, "_tab_taken"}, 64'(pred_taken), 64'(v.et));
            check({name, "_tab_target"}, 64'(pred_target), 64'(v.etgt));
        end
        $display("%s lk=%h uv=%0b upc=%h t=%0b j=%0b clr=%0b -> taken=%0b target=%h br=%0d mp=%0d",
                 name, v.lk, v.uv, v.upc, v.ut, v.uj, v.c, pred_taken, pred_target, br_cnt, mp_cnt);
        @(posedge clk);
        model_update(v);
        #1;
    endtask

    // Reset with an update pending: everything must read as empty, update dropped
    task automatic hard_reset();
        reset = 1'b1;
        lk_pc = 32'h40; upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        upd_target = 32'h100; upd_jump = 1'b0; upd_mispred = 1'b1; clr = 1'b0;
        #1;
        check("rst_taken", 64'(pred_taken), 64'd0);
        check("rst_target", 64'(pred_target), 64'h44);
        check("rst_br", 64'(br_cnt), 64'd0);
        check("rst_mp", 64'(mp_cnt), 64'd0);
        @(posedge clk); #1;
        check("rst_hold_taken", 64'(pred_taken), 64'd0);
        check("rst_hold_br", 64'(br_cnt4), 64'd0);
        @(negedge clk);
        reset = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
        model_reset();
        @(posedge clk); #1;
        $display("reset applied");
    endtask

    function automatic vec_t mk(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic uj,
                                input logic ump, input logic c, input logic et,
                                input logic [31:0] etgt);
        vec_t v;
        v.lk = lk; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.uj = uj; v.ump = ump; v.c = c; v.et = et; v.etgt = etgt;
        return v;
    endfunction

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        if ($urandom_range(0, 19) == 0) p = $urandom;
        else p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
        return p;
    endfunction

    vec_t tab [14];

    initial begin
        vec_t v;
        logic [31:0] xpc;
        reset = 1'b1;
        lk_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
        upd_jump = 0; upd_mispred = 0; clr = 0;
        model_reset();
        @(posedge clk); #1;
        hard_reset();

        //              lk      uv  upc     t  tgt     j  mp c  exp_t exp_tgt
        tab[0]  = mk(32'h40,  0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h44);
        tab[1]  = mk(32'h40,  1, 32'h40,  1, 32'h100, 0, 1, 0, 0, 32'h44);
        tab[2]  = mk(32'h40,  0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 32'h100);
        tab[3]  = mk(32'h80,  0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h84);
        tab[4]  = mk(32'h40,  1, 32'h40,  0, 32'h0,   0, 1, 0, 1, 32'h100);
        tab[5]  = mk(32'h40,  1, 32'h40,  0, 32'h0,   0, 0, 0, 0, 32'h100);
        tab[6]  = mk(32'h40,  1, 32'h40,  1, 32'h100, 0, 1, 0, 0, 32'h100);
        tab[7]  = mk(32'h40,  1, 32'h40,  1, 32'h100, 0, 0, 0, 0, 32'h100);
        tab[8]  = mk(32'h40,  0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 32'h100);
        tab[9]  = mk(32'h200, 1, 32'h200, 1, 32'h300, 1, 0, 0, 0, 32'h204);
        tab[10] = mk(32'h200, 1, 32'h200, 0, 32'h0,   0, 1, 0, 1, 32'h300);
        tab[11] = mk(32'h200, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 32'h300);
        tab[12] = mk(32'h200, 0, 32'h0,   0, 32'h0,   0, 0, 1, 1, 32'h300);
        tab[13] = mk(32'h200, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h204);
        for (int i = 0; i < 14; i++) apply(tab[i], 1'b1, $sformatf("tab%0d", i));

        // Jump, not-taken conditional, then clear: direction held, stats kept
        hard_reset();
        apply(mk(32'h200, 1, 32'h200, 1, 32'h300, 1, 0, 0, 0, 32'h204), 1'b1, "jmp");
        apply(mk(32'h200, 1, 32'h200, 0, 32'h0,   0, 0, 0, 1, 32'h300), 1'b1, "jmp_nt");
        apply(mk(32'h200, 0, 32'h0,   0, 32'h0,   0, 0, 1, 1, 32'h300), 1'b1, "clr");
        apply(mk(32'h200, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h204), 1'b1, "post_clr");
        check("clr_br_kept", 64'(br_cnt), 64'd2);
        check("clr_mp_kept", 64'(mp_cnt), 64'd0);

        // Counter saturation on the 4-bit instance, then asynchronous reset mid-update
        hard_reset();
        for (int i = 0; i < 20; i++)
            apply(mk(rnd_pc(), 1, rnd_pc(), 1'($urandom_range(0, 1)), $urandom, 0, 1, 0, 0, 0),
                  1'b0, $sformatf("sat%0d", i));
        check("sat_br4", 64'(br_cnt4), 64'd15);
        check("sat_mp4", 64'(mp_cnt4), 64'd15);
        check("sat_br32", 64'(br_cnt), 64'd20);
        xpc = 32'h3c0;
        lk_pc = xpc; upd_valid = 1; upd_pc = xpc; upd_taken = 1; upd_target = 32'h500;
        upd_jump = 1; upd_mispred = 1; clr = 0;
        #2;
        reset = 1'b1;
        #1;
        check("async_br", 64'(br_cnt), 64'd0);
        check("async_mp", 64'(mp_cnt), 64'd0);
        check("async_br4", 64'(br_cnt4), 64'd0);
        check("async_mp4", 64'(mp_cnt4), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; upd_valid = 0;
        model_reset();
        @(posedge clk); #1;
        $display("async reset applied mid-update");
        apply(mk(xpc, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, xpc + 32'd4), 1'b1, "after_async");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            v.lk   = ($urandom_range(0, 2) == 0) ? upd_pc : rnd_pc();
            v.c    = ($urandom_range(0, 39) == 0);
            v.uv   = v.c ? 1'b0 : ($urandom_range(0, 9) < 7);
            v.upc  = rnd_pc();
            v.ut   = 1'($urandom_range(0, 1));
            v.utgt = $urandom & 32'hffff_fffc;
            v.uj   = ($urandom_range(0, 4) == 0);
            v.ump  = 1'($urandom_range(0, 1));
            v.et   = 0;
            v.etgt = '0;
            apply(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
